// File: rtl/tb_riscv_memory.sv
// Unified instruction/data memory model that answers CPU fetches and loads/stores.
// Fetches return after one edge. Loads return after RD_LATENCY edges, one at a time.
// Stores complete in one cycle. Preload is only possible while the CPU is held in reset.
module tb_riscv_memory #(
  parameter int DEPTH_LOG2 = 10,
  parameter int RD_LATENCY = 2
) (
  input  logic        CLK,
  input  logic        RST_n,
  input  logic [31:0] INSTR_ADDR,
  output logic [31:0] INSTR,
  input  logic [31:0] DATA_ADDR,
  input  logic [31:0] DATA_WR,
  input  logic        WR_EN,
  input  logic        RD_EN,
  output logic [31:0] DATA_RD,
  output logic        DATA_VALID,
  output logic        BUSY,
  output logic        MISALIGNED,
  output logic        PROTO_ERR,
  input  logic        LOAD_EN,
  input  logic [31:0] LOAD_ADDR,
  input  logic [31:0] LOAD_DATA,
  output logic [15:0] RD_COUNT,
  output logic [15:0] WR_COUNT
);

  localparam int Words = 1 << DEPTH_LOG2;
  // WAIT countdown start value; the countdown is unused when RD_LATENCY is 1.
  localparam logic [1:0] CntInit = (RD_LATENCY > 1) ? 2'(RD_LATENCY - 2) : 2'd0;

  if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
    $error("RD_LATENCY must be within 1..4");
  end

  typedef enum logic {StIdle, StWait} state_e;

  logic [31:0] mem_q [Words];

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] hold_q, hold_d;
  logic [31:0] instr_q;
  logic [31:0] data_rd_q, data_rd_d;
  logic        data_valid_q, data_valid_d;
  logic        misaligned_q, misaligned_d;
  logic        proto_err_q, proto_err_d;
  logic [15:0] rd_count_q, rd_count_d;
  logic [15:0] wr_count_q, wr_count_d;
  logic        store_en;

  logic [DEPTH_LOG2-1:0] iidx, didx, lidx;

  // Upper address bits alias onto the array.
  assign iidx = INSTR_ADDR[DEPTH_LOG2+1:2];
  assign didx = DATA_ADDR[DEPTH_LOG2+1:2];
  assign lidx = LOAD_ADDR[DEPTH_LOG2+1:2];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{INSTR_ADDR[31:DEPTH_LOG2+2], INSTR_ADDR[1:0],
                              DATA_ADDR[31:DEPTH_LOG2+2],
                              LOAD_ADDR[31:DEPTH_LOG2+2], LOAD_ADDR[1:0]};

  // Request decode, load FSM next state, flags and counters.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hold_d       = hold_q;
    data_rd_d    = data_rd_q;
    data_valid_d = 1'b0;
    misaligned_d = misaligned_q;
    proto_err_d  = proto_err_q;
    rd_count_d   = rd_count_q;
    wr_count_d   = wr_count_q;
    store_en     = 1'b0;

    // Preload outside reset is a bench mistake; it is never performed.
    if (LOAD_EN) proto_err_d = 1'b1;

    case (state_q)
      StIdle: begin
        if (RD_EN && WR_EN) begin
          proto_err_d = 1'b1;
        end else if (RD_EN) begin
          rd_count_d = rd_count_q + 16'd1;
          if (DATA_ADDR[1:0] != 2'b00) misaligned_d = 1'b1;
          // Array is read before any same-edge write lands.
          if (RD_LATENCY == 1) begin
            data_rd_d    = mem_q[didx];
            data_valid_d = 1'b1;
          end else begin
            hold_d  = mem_q[didx];
            cnt_d   = CntInit;
            state_d = StWait;
          end
        end else if (WR_EN) begin
          store_en   = 1'b1;
          wr_count_d = wr_count_q + 16'd1;
          if (DATA_ADDR[1:0] != 2'b00) misaligned_d = 1'b1;
        end
      end
      StWait: begin
        // Refused requests do not disturb the load in flight.
        if (RD_EN || WR_EN) proto_err_d = 1'b1;
        if (cnt_q == 2'd0) begin
          data_rd_d    = hold_q;
          data_valid_d = 1'b1;
          state_d      = StIdle;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control registers and fetch port; reset aborts any load in flight.
  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      state_q      <= StIdle;
      cnt_q        <= 2'd0;
      hold_q       <= 32'd0;
      instr_q      <= 32'd0;
      data_rd_q    <= 32'd0;
      data_valid_q <= 1'b0;
      misaligned_q <= 1'b0;
      proto_err_q  <= 1'b0;
      rd_count_q   <= 16'd0;
      wr_count_q   <= 16'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hold_q       <= hold_d;
      instr_q      <= mem_q[iidx];
      data_rd_q    <= data_rd_d;
      data_valid_q <= data_valid_d;
      misaligned_q <= misaligned_d;
      proto_err_q  <= proto_err_d;
      rd_count_q   <= rd_count_d;
      wr_count_q   <= wr_count_d;
    end
  end

  // Storage array: preload while in reset, CPU stores otherwise; never cleared.
  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      if (LOAD_EN) mem_q[lidx] <= LOAD_DATA;
    end else if (store_en) begin
      mem_q[didx] <= DATA_WR;
    end
  end

  assign INSTR      = instr_q;
  assign DATA_RD    = data_rd_q;
  assign DATA_VALID = data_valid_q;
  assign BUSY       = (state_q == StWait);
  assign MISALIGNED = misaligned_q;
  assign PROTO_ERR  = proto_err_q;
  assign RD_COUNT   = rd_count_q;
  assign WR_COUNT   = wr_count_q;

endmodule

// File: tb/tb_tb_riscv_memory.sv
// Self-checking bench for tb_riscv_memory.
// Expected load data is queued when a load is issued and checked on each DATA_VALID.
// A second instance with RD_LATENCY=4 covers aborting a load with reset.
module tb_tb_riscv_memory;

  logic        clk;
  logic        rst_n, rst4_n;
  logic [31:0] instr_addr, data_addr, data_wr;
  logic        wr_en, rd_en, wr_en4, rd_en4;
  logic        load_en;
  logic [31:0] load_addr, load_data;

  logic [31:0] instr, data_rd, instr4, data_rd4;
  logic        data_valid, busy, misaligned, proto_err;
  logic        data_valid4, busy4, misaligned4, proto_err4;
  logic [15:0] rd_count, wr_count, rd_count4, wr_count4;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp4_q[$];

  tb_riscv_memory #(.DEPTH_LOG2(10), .RD_LATENCY(2)) u_dut (
    .CLK(clk), .RST_n(rst_n), .INSTR_ADDR(instr_addr), .INSTR(instr),
    .DATA_ADDR(data_addr), .DATA_WR(data_wr), .WR_EN(wr_en), .RD_EN(rd_en),
    .DATA_RD(data_rd), .DATA_VALID(data_valid), .BUSY(busy), .MISALIGNED(misaligned),
    .PROTO_ERR(proto_err), .LOAD_EN(load_en), .LOAD_ADDR(load_addr), .LOAD_DATA(load_data),
    .RD_COUNT(rd_count), .WR_COUNT(wr_count)
  );

  tb_riscv_memory #(.DEPTH_LOG2(10), .RD_LATENCY(4)) u_dut4 (
    .CLK(clk), .RST_n(rst4_n), .INSTR_ADDR(instr_addr), .INSTR(instr4),
    .DATA_ADDR(data_addr), .DATA_WR(data_wr), .WR_EN(wr_en4), .RD_EN(rd_en4),
    .DATA_RD(data_rd4), .DATA_VALID(data_valid4), .BUSY(busy4), .MISALIGNED(misaligned4),
    .PROTO_ERR(proto_err4), .LOAD_EN(load_en), .LOAD_ADDR(load_addr), .LOAD_DATA(load_data),
    .RD_COUNT(rd_count4), .WR_COUNT(wr_count4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every DATA_VALID pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (data_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL dv2_unexpected: got 0x%08h want no pulse", data_rd);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (data_rd !== e) begin
          errors++;
          $display("FAIL dv2_data: got 0x%08h want 0x%08h", data_rd, e);
        end
      end
    end
    if (data_valid4) begin
      checks++;
      if (exp4_q.size() == 0) begin
        errors++;
        $display("FAIL dv4_unexpected: got 0x%08h want no pulse", data_rd4);
      end else begin
        logic [31:0] e;
        e = exp4_q.pop_front();
        if (data_rd4 !== e) begin
          errors++;
          $display("FAIL dv4_data: got 0x%08h want 0x%08h", data_rd4, e);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; rst4_n = 1'b0;
    instr_addr = '0; data_addr = '0; data_wr = '0;
    wr_en = 1'b0; rd_en = 1'b0; wr_en4 = 1'b0; rd_en4 = 1'b0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    tick(2);

    // Preload the program image and a known word at 0x80 under reset.
    load_en = 1'b1;
    load_addr = 32'h0;  load_data = 32'h0050_0093; tick();
    load_addr = 32'h4;  load_data = 32'h00a0_0113; tick();
    load_addr = 32'h80; load_data = 32'h55aa_55aa; tick();
    load_en = 1'b0;
    instr_addr = 32'h4;
    tick();
    chk("rst_instr", instr, 32'h0);
    chk("rst_valid", {31'd0, data_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_misaligned", {31'd0, misaligned}, 32'd0);
    chk("rst_proto_err", {31'd0, proto_err}, 32'd0);
    chk("rst_rd_count", {16'd0, rd_count}, 32'd0);
    chk("rst_wr_count", {16'd0, wr_count}, 32'd0);

    rst_n = 1'b1; rst4_n = 1'b1;
    tick();
    chk("fetch_0x4", instr, 32'h00a0_0113);
    instr_addr = 32'h0;
    tick();
    chk("fetch_0x0", instr, 32'h0050_0093);
    chk("run_flags", {30'd0, misaligned, proto_err}, 32'd0);

    // Store then load at 0x40, latency 2.
    data_addr = 32'h40; data_wr = 32'hdead_beef; wr_en = 1'b1;
    tick();
    chk("st_wr_count", {16'd0, wr_count}, 32'd1);
    wr_en = 1'b0; rd_en = 1'b1;
    exp_q.push_back(32'hdead_beef);
    tick();
    rd_en = 1'b0;
    chk("ld_busy_wait", {31'd0, busy}, 32'd1);
    chk("ld_no_valid_yet", {31'd0, data_valid}, 32'd0);
    chk("ld_rd_count", {16'd0, rd_count}, 32'd1);
    tick();
    chk("ld_valid", {31'd0, data_valid}, 32'd1);
    chk("ld_busy_valid", {31'd0, busy}, 32'd0);
    tick();
    chk("ld_valid_one_cycle", {31'd0, data_valid}, 32'd0);
    chk("ld_proto_clean", {31'd0, proto_err}, 32'd0);

    // RD_EN held six edges: accepted on alternate edges, others refused.
    data_addr = 32'h4; rd_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) exp_q.push_back(32'h00a0_0113);
      tick();
    end
    rd_en = 1'b0;
    chk("b2b_rd_count", {16'd0, rd_count}, 32'd4);
    chk("b2b_proto_err", {31'd0, proto_err}, 32'd1);
    tick();
    chk("b2b_drained", exp_q.size(), 32'd0);

    // Clear flags and counters, then issue RD_EN and WR_EN together.
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("rst2_proto_err", {31'd0, proto_err}, 32'd0);
    data_addr = 32'h80; data_wr = 32'h0000_1234; rd_en = 1'b1; wr_en = 1'b1;
    tick();
    rd_en = 1'b0; wr_en = 1'b0;
    chk("both_proto_err", {31'd0, proto_err}, 32'd1);
    chk("both_counts", {rd_count, wr_count}, 32'd0);
    chk("both_busy", {31'd0, busy}, 32'd0);
    rd_en = 1'b1; exp_q.push_back(32'h55aa_55aa);
    tick();
    rd_en = 1'b0;
    tick(2);

    // Misaligned load and aliased address.
    chk("pre_misaligned", {31'd0, misaligned}, 32'd0);
    data_addr = 32'h43; rd_en = 1'b1; exp_q.push_back(32'hdead_beef);
    tick();
    rd_en = 1'b0;
    chk("mis_flag", {31'd0, misaligned}, 32'd1);
    tick(2);
    data_addr = 32'h1040; rd_en = 1'b1; exp_q.push_back(32'hdead_beef);
    instr_addr = 32'h1004;
    tick();
    rd_en = 1'b0;
    chk("alias_fetch", instr, 32'h00a0_0113);
    tick(2);
    chk("alias_rd_count", {16'd0, rd_count}, 32'd3);

    // Latency-4 instance: reset one cycle after acceptance aborts the load.
    data_addr = 32'h4; rd_en4 = 1'b1;
    tick();
    rd_en4 = 1'b0;
    chk("l4_busy", {31'd0, busy4}, 32'd1);
    rst4_n = 1'b0;
    tick();
    rst4_n = 1'b1;
    chk("l4_abort_busy", {31'd0, busy4}, 32'd0);
    chk("l4_abort_count", {16'd0, rd_count4}, 32'd0);
    tick(5);
    rd_en4 = 1'b1; exp4_q.push_back(32'h00a0_0113);
    tick();
    rd_en4 = 1'b0;
    tick(2);
    chk("l4_not_yet", {31'd0, data_valid4}, 32'd0);
    tick();
    chk("l4_valid", {31'd0, data_valid4}, 32'd1);
    tick();
    chk("l4_rd_count", {16'd0, rd_count4}, 32'd1);

    // Preload strobe outside reset is refused and flagged.
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("rst3_proto_err", {31'd0, proto_err}, 32'd0);
    load_en = 1'b1; load_addr = 32'h0; load_data = 32'hffff_ffff;
    tick();
    load_en = 1'b0;
    chk("late_load_proto", {31'd0, proto_err}, 32'd1);
    data_addr = 32'h0; rd_en = 1'b1; exp_q.push_back(32'h0050_0093);
    tick();
    rd_en = 1'b0;
    tick(3);

    chk("sb2_empty", exp_q.size(), 32'd0);
    chk("sb4_empty", exp4_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tb_riscv_memory.md
Name: tb_riscv_memory

Overview:
- Behavioural unified instruction/data memory for CPU-level simulation; it is the responder side of the CPU fetch and load/store interface.
- Serves registered instruction fetches and data reads with programmable latency. Accepts single-cycle word stores.
- Provides a preload port for the program image, usable only while the CPU is held in reset.
- Flags protocol errors for the bench.

Parameters:
- DEPTH_LOG2, 10, memory holds 2^DEPTH_LOG2 32-bit words; word index = ADDR[DEPTH_LOG2+1:2], upper bits ignored (aliasing).
- RD_LATENCY, 2, data read latency in cycles; legal 1..4. Elaboration fails outside this range.

Ports:
- CLK  in  1  clock, all activity on rising edge
- RST_n  in  1  synchronous active-low reset
- INSTR_ADDR  in  32  fetch byte address
- INSTR  out  32  fetched word
- DATA_ADDR  in  32  load/store byte address
- DATA_WR  in  32  store data (CPU DATA_OUT)
- WR_EN  in  1  store request
- RD_EN  in  1  load request
- DATA_RD  out  32  load data (CPU DATA_IN)
- DATA_VALID  out  1  one-cycle pulse, DATA_RD valid
- BUSY  out  1  read in flight, new requests refused
- MISALIGNED  out  1  sticky, address bits[1:0] nonzero seen
- PROTO_ERR  out  1  sticky, illegal request seen
- LOAD_EN  in  1  preload write strobe, honoured only while RST_n=0
- LOAD_ADDR  in  32  preload byte address
- LOAD_DATA  in  32  preload word
- RD_COUNT  out  16  accepted loads, wraps at 2^16
- WR_COUNT  out  16  performed stores, wraps at 2^16

Behaviour:
- Reset (RST_n=0 at an edge):
  - INSTR, DATA_RD, DATA_VALID, BUSY, MISALIGNED, PROTO_ERR, RD_COUNT and WR_COUNT all go to 0; FSM goes to IDLE.
  - Memory contents are preserved.
  - Any read in flight is aborted with no DATA_VALID.
  - LOAD_EN writes LOAD_DATA to the indexed word; CPU ports are ignored.
- Fetch:
  - Every non-reset edge, INSTR <= mem[INSTR_ADDR index]. One cycle latency, no handshake.
  - Read-before-write: a same-edge store to that word is not visible to the fetch.
- FSM, IDLE:
  - RD_EN=1, WR_EN=0: load accepted. Word is snapshotted from the pre-store array; RD_COUNT increments.
  - If RD_LATENCY=1: DATA_RD/DATA_VALID=1 after the same edge; stay in IDLE.
  - Otherwise: go to WAIT, counter=RD_LATENCY-2, BUSY=1.
- FSM, WAIT:
  - Each edge decrements the counter.
  - At the edge where the counter reaches 0, drive DATA_RD and DATA_VALID=1, BUSY=0, go to IDLE.
  - Result: a load sampled at edge k has DATA_VALID high only in the cycle after edge k+RD_LATENCY-1.
- DATA_VALID is a single-cycle pulse. DATA_RD holds its last value otherwise.
- BUSY is low during the DATA_VALID cycle, so back-to-back loads are sustained at one per RD_LATENCY cycles.
- Stores:
  - WR_EN=1, RD_EN=0, BUSY=0: mem[index] <= DATA_WR at that edge; WR_COUNT increments.
  - A load accepted at the next edge returns the new value.
- Errors (PROTO_ERR set; request neither performed nor counted):
  - RD_EN and WR_EN both high.
  - Any request while BUSY=1. The in-flight read is unaffected.
- Misaligned address on an accepted request: MISALIGNED is set and the access proceeds at the aligned word.
- Sticky flags clear only on reset.
- Counters wrap 0xFFFF -> 0x0000.
- LOAD_EN with RST_n=1 is ignored and sets PROTO_ERR.

Test Plan:
- Preload under reset: words 0x00500093 at addr 0x0 and 0x00a00113 at addr 0x4. Release reset, INSTR_ADDR=0x4 -> INSTR=0x00a00113 after one edge; all flags and counters 0.
- RD_LATENCY=2: store 0xDEADBEEF at 0x40 at edge 1, RD_EN at 0x40 at edge 2:
  - BUSY=1 between edges 2 and 3.
  - DATA_VALID=1 with DATA_RD=0xDEADBEEF for exactly the cycle after edge 3.
  - RD_COUNT=1, WR_COUNT=1.
- RD_EN held high for 6 edges, RD_LATENCY=2: 3 loads accepted, 3 DATA_VALID pulses, RD_COUNT=3, PROTO_ERR=1 from the refused mid-flight requests.
- RD_EN and WR_EN both high at 0x80 with DATA_WR=0x1234 -> mem[0x80] unchanged, no DATA_VALID, PROTO_ERR=1, counters unchanged.
- Load at 0x43 -> MISALIGNED=1, DATA_RD=mem[0x40]. Address 0x1040 with DEPTH_LOG2=10 aliases to 0x040.
- RST_n low one cycle after a RD_LATENCY=4 load is accepted -> DATA_VALID never asserts, BUSY=0, memory intact on the next load.
